// File: rtl/core_pkg.sv
// Shared core definitions: pipeline-control FSM state encoding and the
// default refill depth used by pipe_ctrl.
package core_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    RUN    = 2'd1,
    REFILL = 2'd2
  } pipe_state_t;

  localparam int unsigned REFILL_CYCLES_DEF = 2;

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit event counter that increments on 'inc' and sticks at 16'hFFFF.
module sat_cnt16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stage enables, valid bits, fill/refill FSM.
// Optional PIPE_CTRL_PERF_EN adds saturating flush/bubble event counters.
module pipe_ctrl
  import core_pkg::*;
#(
  parameter int unsigned REFILL_CYCLES = REFILL_CYCLES_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_id_flush,
  input  logic        i_ex_flush,
  input  logic        i_bubble,
  input  logic        i_mem_wait,
  output logic        o_pc_en,
  output logic        o_ifid_en,
  output logic        o_idex_en,
  output logic        o_exwb_en,
  output logic        o_id_vld,
  output logic        o_ex_vld,
  output logic        o_wb_vld,
`ifdef PIPE_CTRL_PERF_EN
  output logic [15:0] o_flush_cnt,
  output logic [15:0] o_bubble_cnt,
`endif
  output logic        o_refill
);

  localparam logic [1:0] CNT_INIT   = 2'(REFILL_CYCLES);
  // The flush cycle itself counts as the first refill cycle.
  localparam logic [1:0] CNT_RELOAD = 2'(REFILL_CYCLES - 1);

  pipe_state_t state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic        pend_id, pend_ex;
  logic        id_vld, ex_vld, wb_vld;
  logic        id_fl, ex_fl, fetch_ok;

  assign id_fl    = i_id_flush | pend_id;
  assign ex_fl    = i_ex_flush | pend_ex;
  assign fetch_ok = (state == RUN) | (cnt == 2'd1);

  assign o_id_vld = id_vld;
  assign o_ex_vld = ex_vld;
  assign o_wb_vld = wb_vld;

  always_comb begin
    o_pc_en   = 1'b0;
    o_ifid_en = 1'b0;
    o_idex_en = 1'b0;
    o_exwb_en = 1'b0;
    if (!i_mem_wait) begin
      o_pc_en   = ~i_bubble;
      o_ifid_en = ~i_bubble;
      o_idex_en = 1'b1;
      o_exwb_en = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= FILL;
      cnt   <= CNT_INIT;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    o_refill  = (state != RUN);
    if (!i_mem_wait) begin
      if (id_fl) begin
        // A one-cycle refill depth is fully covered by the flush cycle.
        if (CNT_RELOAD == 2'd0) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = CNT_RELOAD;
          if (state == RUN) begin
            state_nxt = REFILL;
          end
        end
      end else if (state != RUN) begin
        if (cnt == 2'd1) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end
    end
  end

  // Flushes seen while frozen are parked and replayed on the first free cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      id_vld  <= 1'b0;
      ex_vld  <= 1'b0;
      wb_vld  <= 1'b0;
      pend_id <= 1'b0;
      pend_ex <= 1'b0;
    end else if (i_mem_wait) begin
      pend_id <= pend_id | i_id_flush;
      pend_ex <= pend_ex | i_ex_flush;
    end else begin
      wb_vld  <= ex_vld;
      ex_vld  <= id_vld & ~ex_fl & ~i_bubble;
      if (id_fl) begin
        id_vld <= 1'b0;
      end else if (!i_bubble) begin
        id_vld <= fetch_ok;
      end
      pend_id <= 1'b0;
      pend_ex <= 1'b0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  sat_cnt16 u_flush_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .inc   (~i_mem_wait & (id_fl | ex_fl)),
    .count (o_flush_cnt)
  );

  sat_cnt16 u_bubble_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .inc   (~i_mem_wait & i_bubble & ~id_fl),
    .count (o_bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic
// against a cycles-since-kill reference model.
module tb_pipe_ctrl;

  localparam int RC = 2;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_id_flush = 1'b0, i_ex_flush = 1'b0, i_bubble = 1'b0, i_mem_wait = 1'b0;
  logic o_pc_en, o_ifid_en, o_idex_en, o_exwb_en;
  logic o_id_vld, o_ex_vld, o_wb_vld, o_refill;
`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] o_flush_cnt, o_bubble_cnt;
`endif

  int vectors = 0;
  int errors  = 0;

  // Reference model: pipeline occupancy plus cycles elapsed since last kill.
  logic m_id, m_ex, m_wb, m_pid, m_pex;
  int   m_since, m_fc, m_bc;

  always #5 i_clk = ~i_clk;

  pipe_ctrl #(.REFILL_CYCLES(RC)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_id_flush   (i_id_flush),
    .i_ex_flush   (i_ex_flush),
    .i_bubble     (i_bubble),
    .i_mem_wait   (i_mem_wait),
    .o_pc_en      (o_pc_en),
    .o_ifid_en    (o_ifid_en),
    .o_idex_en    (o_idex_en),
    .o_exwb_en    (o_exwb_en),
    .o_id_vld     (o_id_vld),
    .o_ex_vld     (o_ex_vld),
    .o_wb_vld     (o_wb_vld),
`ifdef PIPE_CTRL_PERF_EN
    .o_flush_cnt  (o_flush_cnt),
    .o_bubble_cnt (o_bubble_cnt),
`endif
    .o_refill     (o_refill)
  );

  task automatic model_reset();
    m_id = 0; m_ex = 0; m_wb = 0; m_pid = 0; m_pex = 0;
    m_since = 0; m_fc = 0; m_bc = 0;
  endtask

  // Bit order: pc_en ifid_en idex_en exwb_en id_vld ex_vld wb_vld refill
  function automatic logic [7:0] expected();
    logic en;
    en = ~i_mem_wait;
    return {en & ~i_bubble, en & ~i_bubble, en, en, m_id, m_ex, m_wb, 1'(m_since < RC)};
  endfunction

  function automatic logic [7:0] observed();
    return {o_pc_en, o_ifid_en, o_idex_en, o_exwb_en, o_id_vld, o_ex_vld, o_wb_vld, o_refill};
  endfunction

  task automatic drive(input logic idf, input logic exf, input logic bub, input logic mw);
    i_id_flush = idf;
    i_ex_flush = exf;
    i_bubble   = bub;
    i_mem_wait = mw;
    #1;
  endtask

  // Advance the model with the current inputs, then move to the next low phase.
  task automatic tick();
    logic idfl, exfl, fok;
    if (!i_rst_n) begin
      model_reset();
    end else if (i_mem_wait) begin
      m_pid = m_pid | i_id_flush;
      m_pex = m_pex | i_ex_flush;
    end else begin
      idfl = i_id_flush | m_pid;
      exfl = i_ex_flush | m_pex;
      fok  = (m_since >= RC - 1);
      if (idfl | exfl) m_fc = (m_fc < 65535) ? m_fc + 1 : m_fc;
      if (i_bubble & ~idfl) m_bc = (m_bc < 65535) ? m_bc + 1 : m_bc;
      m_wb = m_ex;
      m_ex = m_id & ~exfl & ~i_bubble;
      if (idfl) m_id = 0;
      else if (!i_bubble) m_id = fok;
      m_since = idfl ? 1 : ((m_since + 1 > RC) ? RC : m_since + 1);
      m_pid = 0;
      m_pex = 0;
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic test_cold_start();
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 0, 0);
      vectors++;
      if (observed() !== expected()) begin
        errors++;
        $display("[TB] FAIL cold_start cyc%0d: got %b want %b", k, observed(), expected());
      end
      vectors++;
      if ({o_id_vld, o_ex_vld, o_wb_vld, o_refill} !== {1'(k >= 2), 1'(k >= 3), 1'(k >= 4), 1'(k < 2)}) begin
        errors++;
        $display("[TB] FAIL cold_start_table cyc%0d: got %b want %b", k,
                 {o_id_vld, o_ex_vld, o_wb_vld, o_refill},
                 {1'(k >= 2), 1'(k >= 3), 1'(k >= 4), 1'(k < 2)});
      end
      tick();
    end
  endtask

  task automatic test_reset();
    #2;
    i_rst_n = 1'b0;
    model_reset();
    drive(0, 0, 0, 0);
    vectors++;
    if (observed() !== expected()) begin
      errors++;
      $display("[TB] FAIL reset_async: got %b want %b", observed(), expected());
    end
    tick();
    drive(0, 0, 0, 1);
    vectors++;
    if (observed() !== expected()) begin
      errors++;
      $display("[TB] FAIL reset_wait: got %b want %b", observed(), expected());
    end
    tick();
    i_rst_n = 1'b1;
    test_cold_start();
  endtask

  task automatic test_bubble();
    logic [3:0] seq [4] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000};
    for (int k = 0; k < 4; k++) begin
      drive(seq[k][3], seq[k][2], seq[k][1], seq[k][0]);
      vectors++;
      if (observed() !== expected()) begin
        errors++;
        $display("[TB] FAIL bubble cyc%0d: got %b want %b", k, observed(), expected());
      end
      if (k == 2) begin
        vectors++;
        if ({o_id_vld, o_ex_vld} !== 2'b10) begin
          errors++;
          $display("[TB] FAIL bubble_hold: id/ex got %b want 10", {o_id_vld, o_ex_vld});
        end
      end
      if (k == 3) begin
        vectors++;
        if (o_wb_vld !== 1'b0) begin
          errors++;
          $display("[TB] FAIL bubble_wb: got %b want 0", o_wb_vld);
        end
      end
      tick();
    end
  endtask

  task automatic test_branch();
    logic [3:0] seq [4] = '{4'b1100, 4'b0000, 4'b0000, 4'b0000};
    for (int k = 0; k < 4; k++) begin
      drive(seq[k][3], seq[k][2], seq[k][1], seq[k][0]);
      vectors++;
      if (observed() !== expected()) begin
        errors++;
        $display("[TB] FAIL branch cyc%0d: got %b want %b", k, observed(), expected());
      end
      if (k == 1) begin
        vectors++;
        if ({o_id_vld, o_ex_vld, o_refill} !== 3'b001) begin
          errors++;
          $display("[TB] FAIL branch_kill: id/ex/refill got %b want 001", {o_id_vld, o_ex_vld, o_refill});
        end
      end
      if (k == 2) begin
        vectors++;
        if ({o_id_vld, o_refill} !== 2'b10) begin
          errors++;
          $display("[TB] FAIL branch_refill: id/refill got %b want 10", {o_id_vld, o_refill});
        end
      end
      tick();
    end
  endtask

  task automatic test_mem_wait();
    logic [3:0] seq [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0101,
                            4'b0001, 4'b0000, 4'b0000, 4'b0000};
    for (int k = 0; k < 9; k++) begin
      drive(seq[k][3], seq[k][2], seq[k][1], seq[k][0]);
      vectors++;
      if (observed() !== expected()) begin
        errors++;
        $display("[TB] FAIL mem_wait cyc%0d: got %b want %b", k, observed(), expected());
      end
      if (k >= 3) begin
        vectors++;
        if (o_ex_vld !== 1'(k != 7)) begin
          errors++;
          $display("[TB] FAIL mem_wait_ex cyc%0d: got %b want %b", k, o_ex_vld, 1'(k != 7));
        end
      end
      tick();
    end
  endtask

  task automatic test_refill_reflush();
    logic [3:0] seq [5] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    for (int k = 0; k < 5; k++) begin
      drive(seq[k][3], seq[k][2], seq[k][1], seq[k][0]);
      vectors++;
      if (observed() !== expected()) begin
        errors++;
        $display("[TB] FAIL reflush cyc%0d: got %b want %b", k, observed(), expected());
      end
      if (k == 2 || k == 3) begin
        vectors++;
        if ({o_id_vld, o_refill} !== ((k == 2) ? 2'b01 : 2'b10)) begin
          errors++;
          $display("[TB] FAIL reflush_run cyc%0d: id/refill got %b want %b", k,
                   {o_id_vld, o_refill}, (k == 2) ? 2'b01 : 2'b10);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      drive(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0));
      vectors++;
      if (observed() !== expected()) begin
        errors++;
        $display("[TB] FAIL random cyc%0d: got %b want %b (in %b%b%b%b)", k, observed(), expected(),
                 i_id_flush, i_ex_flush, i_bubble, i_mem_wait);
      end
      tick();
    end
`ifdef PIPE_CTRL_PERF_EN
    vectors++;
    if ({o_flush_cnt, o_bubble_cnt} !== {16'(m_fc), 16'(m_bc)}) begin
      errors++;
      $display("[TB] FAIL random_perf: got %0d/%0d want %0d/%0d", o_flush_cnt, o_bubble_cnt, m_fc, m_bc);
    end
`endif
  endtask

`ifdef PIPE_CTRL_PERF_EN
  task automatic test_perf();
    logic [3:0] seq [15] = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0010,
                             4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0010,
                             4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    vectors++;
    if ({o_flush_cnt, o_bubble_cnt} !== 32'd0) begin
      errors++;
      $display("[TB] FAIL perf_reset: got %0d/%0d want 0/0", o_flush_cnt, o_bubble_cnt);
    end
    for (int k = 0; k < 15; k++) begin
      drive(seq[k][3], seq[k][2], seq[k][1], seq[k][0]);
      tick();
    end
    drive(0, 0, 0, 0);
    vectors++;
    if ({o_flush_cnt, o_bubble_cnt} !== {16'd3, 16'd2}) begin
      errors++;
      $display("[TB] FAIL perf_counts: got %0d/%0d want 3/2", o_flush_cnt, o_bubble_cnt);
    end
    drive(0, 0, 1, 0);
    for (int k = 0; k < 70000; k++) tick();
    drive(0, 0, 0, 0);
    vectors++;
    if ({o_flush_cnt, o_bubble_cnt} !== {16'd3, 16'hFFFF}) begin
      errors++;
      $display("[TB] FAIL perf_saturate: got %0d/%0d want 3/65535", o_flush_cnt, o_bubble_cnt);
    end
  endtask
`endif

  initial begin
    $display("[TB] pipe_ctrl bench start");
    test_reset();
    test_bubble();
    test_branch();
    test_mem_wait();
    test_refill_reflush();
    test_random();
    test_reset();
    test_bubble();
`ifdef PIPE_CTRL_PERF_EN
    test_reset();
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
